// File: rtl/sudoku_edit_ctrl.sv
// Sudoku edit sequencer: keyboard decode, guarded board writes, conflict scan, fill tracking.
// Optional feature: define SUDOKU_CURSOR_WRAP_EN to wrap the cursor at the board edges (default saturates).
module sudoku_edit_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_key_valid,
    input  logic [4:0]  i_key_code,
    input  logic [80:0] i_given_mask,
    output logic [6:0]  o_rd_idx,
    input  logic [3:0]  i_rd_data,
    output logic        o_wr_req,
    output logic [6:0]  o_wr_idx,
    output logic [3:0]  o_wr_data,
    input  logic        i_wr_ack,
    output logic [3:0]  o_cur_x,
    output logic [3:0]  o_cur_y,
    output logic [3:0]  o_digit,
    output logic        o_busy,
    output logic        o_given_hit,
    output logic        o_wr_fail,
    output logic        o_conflict,
    output logic [6:0]  o_filled_cnt,
    output logic        o_solved
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RDOLD, S_WRITE, S_SCAN} state_t;

`ifdef SUDOKU_CURSOR_WRAP_EN
    localparam logic [3:0] DEC_AT_MIN = 4'd8;
    localparam logic [3:0] INC_AT_MAX = 4'd0;
`else
    localparam logic [3:0] DEC_AT_MIN = 4'd0;
    localparam logic [3:0] INC_AT_MAX = 4'd8;
`endif

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [3:0]  r_cur_x, r_cur_y, r_digit;
    logic [3:0]  r_old;
    logic [6:0]  r_widx;
    logic [3:0]  r_to_cnt;
    logic        r_hit;
    logic        r_wr_req;
    logic [6:0]  r_wr_idx;
    logic [3:0]  r_wr_data;
    logic        r_given_hit, r_wr_fail, r_conflict, r_solved;
    logic [6:0]  r_filled;

    logic [6:0]  w_cur_idx;
    logic [6:0]  w_scan_idx;
    logic [3:0]  w_sx, w_sy, w_b;
    logic [3:0]  w_nx, w_ny;
    logic        w_hit;

    function automatic logic [3:0] base3(input logic [3:0] v);
        if (v >= 4'd6)      return 4'd6;
        else if (v >= 4'd3) return 4'd3;
        else                return 4'd0;
    endfunction

    function automatic logic [3:0] row3(input logic [3:0] b);
        if (b >= 4'd6)      return 4'd2;
        else if (b >= 4'd3) return 4'd1;
        else                return 4'd0;
    endfunction

    assign w_cur_idx = 7'(r_cur_y) * 7'd9 + 7'(r_cur_x);

    // Scan step 0..8 walks the row, 9..17 the column, 18..26 the 3x3 box.
    always_comb begin
        w_sx = r_cur_x;
        w_sy = r_cur_y;
        w_b  = 4'd0;
        if (r_cnt < 7'd9) begin
            w_sx = r_cnt[3:0];
        end else if (r_cnt < 7'd18) begin
            w_sy = 4'(r_cnt - 7'd9);
        end else begin
            w_b  = 4'(r_cnt - 7'd18);
            w_sx = base3(r_cur_x) + 4'(w_b - row3(w_b) * 4'd3);
            w_sy = base3(r_cur_y) + row3(w_b);
        end
        w_scan_idx = 7'(w_sy) * 7'd9 + 7'(w_sx);
    end

    always_comb begin
        case (r_state)
            S_INIT:  o_rd_idx = r_cnt;
            S_SCAN:  o_rd_idx = w_scan_idx;
            default: o_rd_idx = w_cur_idx;
        endcase
    end

    assign w_hit = (i_rd_data == r_wr_data) && (w_scan_idx != r_widx);

    always_comb begin
        w_nx = r_cur_x;
        w_ny = r_cur_y;
        case (i_key_code)
            5'h10:   w_ny = (r_cur_y == 4'd0) ? DEC_AT_MIN : r_cur_y - 4'd1;
            5'h11:   w_ny = (r_cur_y == 4'd8) ? INC_AT_MAX : r_cur_y + 4'd1;
            5'h12:   w_nx = (r_cur_x == 4'd0) ? DEC_AT_MIN : r_cur_x - 4'd1;
            5'h13:   w_nx = (r_cur_x == 4'd8) ? INC_AT_MAX : r_cur_x + 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_INIT;
            r_cnt       <= 7'd0;
            r_cur_x     <= 4'd0;
            r_cur_y     <= 4'd0;
            r_digit     <= 4'd0;
            r_old       <= 4'd0;
            r_widx      <= 7'd0;
            r_to_cnt    <= 4'd0;
            r_hit       <= 1'b0;
            r_wr_req    <= 1'b0;
            r_wr_idx    <= 7'd0;
            r_wr_data   <= 4'd0;
            r_given_hit <= 1'b0;
            r_wr_fail   <= 1'b0;
            r_conflict  <= 1'b0;
            r_filled    <= 7'd0;
            r_solved    <= 1'b0;
        end else begin
            r_given_hit <= 1'b0;
            r_wr_fail   <= 1'b0;
            r_solved    <= (r_filled == 7'd81) && !r_conflict;
            case (r_state)
                S_INIT: begin
                    if (i_rd_data != 4'd0)
                        r_filled <= r_filled + 7'd1;
                    if (r_cnt == 7'd80) begin
                        r_cnt   <= 7'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_IDLE: begin
                    if (i_key_valid) begin
                        if (i_key_code <= 5'd9) begin
                            r_digit <= i_key_code[3:0];
                        end else if (i_key_code >= 5'h10 && i_key_code <= 5'h13) begin
                            r_cur_x <= w_nx;
                            r_cur_y <= w_ny;
                        end else if (i_key_code == 5'h1C) begin
                            if (i_given_mask[w_cur_idx])
                                r_given_hit <= 1'b1;
                            else
                                r_state <= S_RDOLD;
                        end
                    end
                end
                S_RDOLD: begin
                    r_old     <= i_rd_data;
                    r_widx    <= w_cur_idx;
                    r_wr_req  <= 1'b1;
                    r_wr_idx  <= w_cur_idx;
                    r_wr_data <= r_digit;
                    r_to_cnt  <= 4'(ACK_TIMEOUT - 1);
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (i_wr_ack) begin
                        r_wr_req <= 1'b0;
                        if (r_old == 4'd0 && r_wr_data != 4'd0)
                            r_filled <= r_filled + 7'd1;
                        else if (r_old != 4'd0 && r_wr_data == 4'd0)
                            r_filled <= r_filled - 7'd1;
                        if (r_wr_data == 4'd0) begin
                            r_conflict <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt   <= 7'd0;
                            r_hit   <= 1'b0;
                            r_state <= S_SCAN;
                        end
                    end else if (r_to_cnt == 4'd0) begin
                        r_wr_req  <= 1'b0;
                        r_wr_fail <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt - 4'd1;
                    end
                end
                S_SCAN: begin
                    r_hit <= r_hit | w_hit;
                    if (r_cnt == 7'd26) begin
                        r_conflict <= r_hit | w_hit;
                        r_cnt      <= 7'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign o_wr_req     = r_wr_req;
    assign o_wr_idx     = r_wr_idx;
    assign o_wr_data    = r_wr_data;
    assign o_cur_x      = r_cur_x;
    assign o_cur_y      = r_cur_y;
    assign o_digit      = r_digit;
    assign o_busy       = (r_state != S_IDLE);
    assign o_given_hit  = r_given_hit;
    assign o_wr_fail    = r_wr_fail;
    assign o_conflict   = r_conflict;
    assign o_filled_cnt = r_filled;
    assign o_solved     = r_solved;

endmodule

// File: tb/tb_sudoku_edit_ctrl.sv
// Randomized bench for sudoku_edit_ctrl against a board-level reference model.
module tb_sudoku_edit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [80:0] given_mask;
    logic [6:0]  rd_idx;
    logic [3:0]  rd_data;
    logic        wr_req;
    logic [6:0]  wr_idx;
    logic [3:0]  wr_data;
    logic        wr_ack;
    logic [3:0]  cur_x, cur_y, digit;
    logic        busy, given_hit, wr_fail, conflict, solved;
    logic [6:0]  filled_cnt;

    always #5 clk = ~clk;

    sudoku_edit_ctrl #(.ACK_TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_code(key_code),
        .i_given_mask(given_mask), .o_rd_idx(rd_idx), .i_rd_data(rd_data),
        .o_wr_req(wr_req), .o_wr_idx(wr_idx), .o_wr_data(wr_data), .i_wr_ack(wr_ack),
        .o_cur_x(cur_x), .o_cur_y(cur_y), .o_digit(digit), .o_busy(busy),
        .o_given_hit(given_hit), .o_wr_fail(wr_fail), .o_conflict(conflict),
        .o_filled_cnt(filled_cnt), .o_solved(solved)
    );

`ifdef SUDOKU_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [3:0] board [0:80];
    bit         given [0:80];
    int n_tests = 0;
    int n_fail  = 0;
    int mx = 0, my = 0, mdig = 0;
    bit mconf = 1'b0;

    assign rd_data = (rd_idx < 7'd81) ? board[rd_idx] : 4'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int count_filled();
        int n = 0;
        for (int j = 0; j < 81; j++)
            if (board[j] != 4'd0) n++;
        return n;
    endfunction

    function automatic bit model_conflict(input int x, input int y, input int d);
        bit c = 1'b0;
        int jx, jy;
        for (int j = 0; j < 81; j++) begin
            jx = j % 9;
            jy = j / 9;
            if (j != y * 9 + x && int'(board[j]) == d &&
                (jx == x || jy == y || (jx / 3 == x / 3 && jy / 3 == y / 3)))
                c = 1'b1;
        end
        return c;
    endfunction

    task automatic press(input logic [4:0] c);
        @(negedge clk); key_valid = 1'b1; key_code = c;
        @(negedge clk); key_valid = 1'b0;
        if (c <= 5'd9) mdig = int'(c);
        else if (c == 5'h10) my = (my == 0) ? (WRAP ? 8 : 0) : my - 1;
        else if (c == 5'h11) my = (my == 8) ? (WRAP ? 0 : 8) : my + 1;
        else if (c == 5'h12) mx = (mx == 0) ? (WRAP ? 8 : 0) : mx - 1;
        else if (c == 5'h13) mx = (mx == 8) ? (WRAP ? 0 : 8) : mx + 1;
        chk("cur_x", cur_x, mx);
        chk("cur_y", cur_y, my);
        chk("digit", digit, mdig);
    endtask

    task automatic goto_cell(input int tx, input int ty);
        while (mx != tx) press(mx < tx ? 5'h13 : 5'h12);
        while (my != ty) press(my < ty ? 5'h11 : 5'h10);
    endtask

    // delay < 0 means never acknowledge
    task automatic do_commit(input int delay);
        int idx, lat;
        idx = my * 9 + mx;
        @(negedge clk); key_valid = 1'b1; key_code = 5'h1C;
        @(negedge clk); key_valid = 1'b0;
        if (given[idx]) begin
            chk("given_hit", given_hit, 1);
            chk("given_busy", busy, 0);
            @(negedge clk);
            chk("given_hit_pulse", given_hit, 0);
            chk("given_no_req", wr_req, 0);
            chk("given_idle", busy, 0);
            return;
        end
        chk("rdold_busy", busy, 1);
        chk("rdold_no_req", wr_req, 0);
        chk("no_given_hit", given_hit, 0);
        @(negedge clk);
        chk("wr_req", wr_req, 1);
        chk("wr_idx", wr_idx, idx);
        chk("wr_data", wr_data, mdig);
        if (delay < 0) begin
            lat = 0;
            while (wr_req === 1'b1 && lat < 40) begin
                lat++;
                @(negedge clk);
            end
            chk("timeout_cycles", lat, 15);
            chk("wr_fail", wr_fail, 1);
            chk("timeout_idle", busy, 0);
            @(negedge clk);
            chk("wr_fail_pulse", wr_fail, 0);
            chk("timeout_filled", filled_cnt, count_filled());
            chk("timeout_conflict", conflict, mconf);
            return;
        end
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("req_held", wr_req, 1);
            chk("idx_stable", wr_idx, idx);
            chk("data_stable", wr_data, mdig);
        end
        wr_ack = 1'b1;
        board[idx] = 4'(mdig);
        @(negedge clk); wr_ack = 1'b0;
        chk("req_dropped", wr_req, 0);
        lat = 0;
        while (busy === 1'b1 && lat < 60) begin
            if (lat == 2) begin key_valid = 1'b1; key_code = 5'h13; end
            if (lat == 3) key_valid = 1'b0;
            lat++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("scan_cycles", lat, (mdig != 0) ? 27 : 0);
        mconf = (mdig == 0) ? 1'b0 : model_conflict(mx, my, mdig);
        chk("conflict", conflict, mconf);
        chk("filled", filled_cnt, count_filled());
        chk("busy_key_ignored", cur_x, mx);
        @(negedge clk);
        chk("solved", solved, (count_filled() == 81 && !mconf));
    endtask

    task automatic wait_init(input string tag);
        int lat = 0;
        while (busy === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, lat, 81);
        chk({tag, "_filled"}, filled_cnt, count_filled());
        @(negedge clk);
        chk({tag, "_solved"}, solved, 0);
        mx = 0; my = 0; mdig = 0; mconf = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] junk [0:5];
        int placed, p, op;
        junk[0] = 5'h0A; junk[1] = 5'h0F; junk[2] = 5'h14;
        junk[3] = 5'h1B; junk[4] = 5'h1D; junk[5] = 5'h1F;
        key_valid = 1'b0; key_code = 5'd0; wr_ack = 1'b0; rst = 1'b1;
        given_mask = '0;
        for (int j = 0; j < 81; j++) begin board[j] = 4'd0; given[j] = 1'b0; end
        placed = 0;
        while (placed < 30) begin
            p = $urandom_range(9, 80);
            if (!given[p]) begin
                given[p] = 1'b1;
                board[p] = 4'($urandom_range(1, 9));
                given_mask[p] = 1'b1;
                placed++;
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rd_idx", rd_idx, 0);
        chk("rst_filled", filled_cnt, 0);
        chk("rst_cursor", {cur_x, cur_y, digit}, 0);
        chk("rst_flags", {given_hit, wr_fail, conflict, solved}, 0);
        chk("rst_wr", {wr_idx, wr_data}, 0);
        rst = 1'b0;
        wait_init("init");
        chk("init_30_givens", filled_cnt, 30);

        press(5'h12);
        press(5'h10);
        press(5'h13);
        press(5'h11);
        goto_cell(0, 0);

        goto_cell(2, 0); press(5'd4); do_commit(0);
        goto_cell(4, 0); press(5'd7); do_commit(1);
        goto_cell(5, 0); do_commit(0);
        chk("row_conflict", conflict, 1);
        press(5'd0); do_commit(0);
        chk("clear_conflict", conflict, 0);

        p = 0;
        while (!given[p]) p++;
        goto_cell(p % 9, p / 9); press(5'd3); do_commit(0);

        goto_cell(6, 0); press(5'd9); do_commit(-1);

        @(negedge clk); wr_ack = 1'b1;
        @(negedge clk); wr_ack = 1'b0;
        chk("stray_ack_idle", busy, 0);
        chk("stray_ack_filled", filled_cnt, count_filled());

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) press(5'h10 + 5'($urandom_range(0, 3)));
            else if (op <= 5) press(5'($urandom_range(0, 9)));
            else if (op == 6) press(junk[$urandom_range(0, 5)]);
            else if (op <= 8) do_commit(($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3)));
            else begin
                @(negedge clk); wr_ack = 1'b1;
                @(negedge clk); wr_ack = 1'b0;
                chk("rand_stray_ack", {busy, wr_req}, 0);
                chk("rand_stray_filled", filled_cnt, count_filled());
            end
        end

        goto_cell(3, 0); press(5'd5);
        @(negedge clk); key_valid = 1'b1; key_code = 5'h1C;
        @(negedge clk); key_valid = 1'b0;
        @(negedge clk); wr_ack = 1'b1; board[3] = 4'd5;
        @(negedge clk); wr_ack = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_scan_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("scan_rst_busy", busy, 1);
        chk("scan_rst_wr_req", wr_req, 0);
        chk("scan_rst_conflict", conflict, 0);
        chk("scan_rst_filled", filled_cnt, 0);
        chk("scan_rst_rd_idx", rd_idx, 0);
        rst = 1'b0;
        wait_init("reinit1");

        goto_cell(3, 0); press(5'd6);
        @(negedge clk); key_valid = 1'b1; key_code = 5'h1C;
        @(negedge clk); key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_write_req", wr_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("write_rst_wr_req", wr_req, 0);
        chk("write_rst_busy", busy, 1);
        rst = 1'b0;
        wait_init("reinit2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sudoku_edit_ctrl.md
# sudoku_edit_ctrl

Edit sequencer for the 9x9 Sudoku board store. It decodes one-cycle keyboard pulses into cursor moves, digit selection and commit requests, and refuses writes to given cells. Each accepted write goes to the board store over a req/ack handshake, then the block scans the edited cell's row, column and box for conflicts. It sits between the keyboard pulse decoder and the board store/VGA renderer, and tracks the filled-cell count and the solved status.

## Interface
Parameters:
- ACK_TIMEOUT, 15: WRITE-state cycles without wr_ack before abort (4-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- key_valid  in  1  one-cycle pulse; key_code valid
- key_code  in  5  0x00 clear-digit, 0x01–0x09 digit, 0x10 up, 0x11 down, 0x12 left, 0x13 right, 0x1C commit; others ignored
- given_mask  in  81  bit i=1 → cell i is fixed
- rd_idx  out  7  board read address, cell index y*9+x
- rd_data  in  4  combinational read data for rd_idx (same cycle)
- wr_req  out  1  write request, held until ack
- wr_idx  out  7  write cell index
- wr_data  out  4  write value (0 = empty)
- wr_ack  in  1  one-cycle write acceptance
- cur_x, cur_y  out  4  cursor column/row, 0–8
- digit  out  4  currently selected digit, 0–9
- busy  out  1  high in any state but IDLE
- given_hit  out  1  one-cycle pulse: commit rejected on fixed cell
- wr_fail  out  1  one-cycle pulse: ack timeout
- conflict  out  1  last committed digit clashes in row/col/box
- filled_cnt  out  7  non-empty cells, 0–81
- solved  out  1  filled_cnt==81 && !conflict

## Operation
- States: INIT, IDLE, RDOLD, WRITE, SCAN.
- INIT (after rst): scan idx 0..80 one per cycle and count rd_data!=0 into filled_cnt. Takes 81 cycles, then IDLE.
- IDLE: handles key_valid. In all other states key_valid is dropped with no queueing.
  - Arrow keys move the cursor by ±1.
  - Digit/clear keys load digit.
  - Commit: if given_mask[idx] then pulse given_hit and stay in IDLE; otherwise go to RDOLD.
- RDOLD: rd_idx = cursor; latch old = rd_data and widx = cursor; go to WRITE.
- WRITE: wr_req=1 with wr_idx=widx and wr_data=digit (digit sampled at commit).
  - On wr_ack, update filled_cnt:
    - old==0 && digit!=0: +1.
    - old!=0 && digit==0: −1.
    - otherwise unchanged.
  - After the wr_ack update: if digit==0, clear conflict and go to IDLE; else go to SCAN.
  - After ACK_TIMEOUT cycles without ack: pulse wr_fail, drop wr_req, go to IDLE, leave filled_cnt unchanged.
- SCAN: 27 steps, one per cycle.
  - Order: row (y fixed, x=0..8), then column (x fixed, y=0..8), then box (base (x/3)*3,(y/3)*3, row-major).
  - A hit is rd_data==digit with index != widx.
  - conflict is updated after step 27 to the OR of all hits.
- Index arithmetic: idx = y*9+x, held in 7 bits; the maximum is 80.

## Timing
- Reset values:
  - Outputs: cur_x=cur_y=0, digit=0, wr_req=0, wr_idx=0, wr_data=0, given_hit=0, wr_fail=0, conflict=0, filled_cnt=0, solved=0, busy=1 (INIT).
  - rd_idx=0; it then follows the scan counter.
- rst asserted in any state, including mid-WRITE or mid-SCAN: next cycle is INIT, wr_req drops immediately, and any partial scan result is discarded.
- Commit latency: key pulse at cycle 0 → RDOLD at cycle 1 → wr_req high at cycle 2.
  - With ack at cycle 2 and digit!=0: SCAN cycles 3–29, conflict valid and busy low at cycle 30.
- Handshake: wr_idx and wr_data are stable while wr_req=1. wr_ack while wr_req=0 is ignored.
- given_hit, wr_fail: exactly one cycle, registered.
- solved is registered and updates the cycle after filled_cnt or conflict changes.

## Configuration
- SUDOKU_CURSOR_WRAP_EN defined: cursor wraps at the edges (left at x=0 → x=8; down at y=8 → y=0; likewise for the other two directions).
- Undefined: cursor saturates at 0 and 8.

## Test plan
- Reset with a board holding 30 givens → busy high for 81 cycles; then filled_cnt=30, solved=0.
- Cursor at (0,0), key 0x12 → with SUDOKU_CURSOR_WRAP_EN cur_x=8; without it cur_x=0.
- Digit 4, commit on empty cell (2,0), ack at first wr_req cycle → wr_idx=2, wr_data=4, filled_cnt +1, conflict=0 if row 0, column 2 and box 0 contain no other 4.
- Commit 7 at (5,0) with 7 already at (4,0) → conflict=1 after 27 SCAN cycles; then clear (0x00)+commit at (5,0) → conflict=0, filled_cnt −1.
- Commit on a given cell → given_hit single pulse, wr_req never asserted, state stays IDLE.
- Hold wr_ack low → wr_fail pulses after 15 WRITE cycles; filled_cnt unchanged; rst asserted mid-SCAN → INIT next cycle and wr_req=0.
